wishbone_arbiter_2m: RTL and testbench

- Two-master, one-slave Wishbone arbiter.
- Lets the instruction-side and data-side Wishbone bus interface modules share the single SOPC slave path (memory/peripheral interconnect).
- Grants the bus per Wishbone cycle and holds the grant while the winner keeps cyc high.
- Routes ack/data back only to the granted master and aborts hung cycles with a timeout error.

---
 rtl/wishbone_arbiter_2m.sv | 207 ++++++++++++++++++++
 tb/tb_wishbone_arbiter_2m.sv | 238 +++++++++++++++++++++++
 2 files changed

// File: rtl/wishbone_arbiter_2m.sv
// Two-master / one-slave Wishbone arbiter with per-cycle grant and hung-cycle timeout.
// Optional feature macro: WB_ARB_ROUND_ROBIN_EN (alternate grant when both masters
// request from idle). When undefined, m1 has strict priority over m0.
module wishbone_arbiter_2m #(
  parameter int unsigned AW             = 32,
  parameter int unsigned DW             = 32,
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic              clk,
  input  logic              rst,
  // master 0 (instruction side)
  input  logic              m0_cyc_i,
  input  logic              m0_stb_i,
  input  logic              m0_we_i,
  input  logic [AW-1:0]     m0_addr_i,
  input  logic [DW-1:0]     m0_data_i,
  input  logic [DW/8-1:0]   m0_sel_i,
  output logic [DW-1:0]     m0_data_o,
  output logic              m0_ack_o,
  output logic              m0_err_o,
  // master 1 (data side)
  input  logic              m1_cyc_i,
  input  logic              m1_stb_i,
  input  logic              m1_we_i,
  input  logic [AW-1:0]     m1_addr_i,
  input  logic [DW-1:0]     m1_data_i,
  input  logic [DW/8-1:0]   m1_sel_i,
  output logic [DW-1:0]     m1_data_o,
  output logic              m1_ack_o,
  output logic              m1_err_o,
  // shared slave path
  output logic              s_cyc_o,
  output logic              s_stb_o,
  output logic              s_we_o,
  output logic [AW-1:0]     s_addr_o,
  output logic [DW-1:0]     s_data_o,
  output logic [DW/8-1:0]   s_sel_o,
  input  logic [DW-1:0]     s_data_i,
  input  logic              s_ack_i,
  // grant status, one-hot
  output logic [1:0]        gnt_o
);

  localparam int unsigned SW       = DW / 8;
  localparam int unsigned CW       = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
  localparam int unsigned TMO_LAST = (TIMEOUT_CYCLES > 0) ? TIMEOUT_CYCLES - 1 : 0;

  typedef enum logic [1:0] {
    ARB_IDLE = 2'd0,
    ARB_M0   = 2'd1,
    ARB_M1   = 2'd2
  } arb_state_e;

  arb_state_e    state_q;
  logic [CW-1:0] cnt_q;
`ifdef WB_ARB_ROUND_ROBIN_EN
  logic          last_q;  // 0 = m0 served last, 1 = m1 served last
`endif

  logic sel_m0;
  logic sel_m1;
  logic act_cyc;
  logic tmo_c;

  // Decode which master currently owns the slave path
  always_comb begin
    sel_m0  = (state_q == ARB_M0);
    sel_m1  = (state_q == ARB_M1);
    act_cyc = (sel_m0 & m0_cyc_i) | (sel_m1 & m1_cyc_i);
  end

  // Timeout fires on the granted cycle that would bring the count to TIMEOUT_CYCLES;
  // a coincident ack wins and suppresses it
  always_comb begin
    tmo_c = 1'b0;
    if (TIMEOUT_CYCLES != 0) begin
      tmo_c = act_cyc && !s_ack_i && (cnt_q == CW'(TMO_LAST));
    end
  end

  // Arbitration state, timeout counter and last-served tracking
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ARB_IDLE;
      cnt_q   <= '0;
`ifdef WB_ARB_ROUND_ROBIN_EN
      last_q  <= 1'b0;
`endif
    end else begin
      case (state_q)
        ARB_IDLE: begin
          cnt_q <= '0;
`ifdef WB_ARB_ROUND_ROBIN_EN
          if (m0_cyc_i && m1_cyc_i) begin
            if (last_q) begin
              state_q <= ARB_M0;
              last_q  <= 1'b0;
            end else begin
              state_q <= ARB_M1;
              last_q  <= 1'b1;
            end
          end else if (m1_cyc_i) begin
            state_q <= ARB_M1;
            last_q  <= 1'b1;
          end else if (m0_cyc_i) begin
            state_q <= ARB_M0;
            last_q  <= 1'b0;
          end
`else
          if (m1_cyc_i) begin
            state_q <= ARB_M1;
          end else if (m0_cyc_i) begin
            state_q <= ARB_M0;
          end
`endif
        end

        ARB_M0: begin
          if (tmo_c) begin
            state_q <= ARB_IDLE;
            cnt_q   <= '0;
          end else if (!m0_cyc_i) begin
            cnt_q <= '0;
            if (m1_cyc_i) begin
              state_q <= ARB_M1;
`ifdef WB_ARB_ROUND_ROBIN_EN
              last_q  <= 1'b1;
`endif
            end else begin
              state_q <= ARB_IDLE;
            end
          end else if (s_ack_i || (TIMEOUT_CYCLES == 0)) begin
            cnt_q <= '0;
          end else if (cnt_q != {CW{1'b1}}) begin
            cnt_q <= cnt_q + CW'(1);
          end
        end

        ARB_M1: begin
          if (tmo_c) begin
            state_q <= ARB_IDLE;
            cnt_q   <= '0;
          end else if (!m1_cyc_i) begin
            cnt_q <= '0;
            if (m0_cyc_i) begin
              state_q <= ARB_M0;
`ifdef WB_ARB_ROUND_ROBIN_EN
              last_q  <= 1'b0;
`endif
            end else begin
              state_q <= ARB_IDLE;
            end
          end else if (s_ack_i || (TIMEOUT_CYCLES == 0)) begin
            cnt_q <= '0;
          end else if (cnt_q != {CW{1'b1}}) begin
            cnt_q <= cnt_q + CW'(1);
          end
        end

        default: begin
          state_q <= ARB_IDLE;
          cnt_q   <= '0;
        end
      endcase
    end
  end

  // Slave request mux; cyc/stb are dropped on the timeout cycle to abort the transfer
  always_comb begin
    s_cyc_o  = 1'b0;
    s_stb_o  = 1'b0;
    s_we_o   = 1'b0;
    s_addr_o = '0;
    s_data_o = '0;
    s_sel_o  = '0;
    if (sel_m0) begin
      s_cyc_o  = m0_cyc_i & ~tmo_c;
      s_stb_o  = m0_stb_i & ~tmo_c;
      s_we_o   = m0_we_i;
      s_addr_o = m0_addr_i;
      s_data_o = m0_data_i;
      s_sel_o  = m0_sel_i;
    end else if (sel_m1) begin
      s_cyc_o  = m1_cyc_i & ~tmo_c;
      s_stb_o  = m1_stb_i & ~tmo_c;
      s_we_o   = m1_we_i;
      s_addr_o = m1_addr_i;
      s_data_o = m1_data_i;
      s_sel_o  = m1_sel_i;
    end
  end

  // Response demux; the non-granted master sees all zeros
  always_comb begin
    m0_data_o = sel_m0 ? s_data_i : '0;
    m0_ack_o  = sel_m0 & s_ack_i;
    m0_err_o  = sel_m0 & tmo_c;
    m1_data_o = sel_m1 ? s_data_i : '0;
    m1_ack_o  = sel_m1 & s_ack_i;
    m1_err_o  = sel_m1 & tmo_c;
    gnt_o     = {sel_m1, sel_m0};
  end

  logic unused_sw;
  assign unused_sw = (SW == 0);

endmodule

// File: tb/tb_wishbone_arbiter_2m.sv
// Directed self-checking bench for wishbone_arbiter_2m (timeout shortened to 8 cycles).
module tb_wishbone_arbiter_2m;

  localparam int unsigned AW  = 32;
  localparam int unsigned DW  = 32;
  localparam int unsigned TMO = 8;

  logic          clk = 1'b0;
  logic          rst;
  logic          m0_cyc_i, m0_stb_i, m0_we_i;
  logic [AW-1:0] m0_addr_i;
  logic [DW-1:0] m0_data_i;
  logic [3:0]    m0_sel_i;
  logic [DW-1:0] m0_data_o;
  logic          m0_ack_o, m0_err_o;
  logic          m1_cyc_i, m1_stb_i, m1_we_i;
  logic [AW-1:0] m1_addr_i;
  logic [DW-1:0] m1_data_i;
  logic [3:0]    m1_sel_i;
  logic [DW-1:0] m1_data_o;
  logic          m1_ack_o, m1_err_o;
  logic          s_cyc_o, s_stb_o, s_we_o;
  logic [AW-1:0] s_addr_o;
  logic [DW-1:0] s_data_o;
  logic [3:0]    s_sel_o;
  logic [DW-1:0] s_data_i;
  logic          s_ack_i;
  logic [1:0]    gnt_o;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  wishbone_arbiter_2m #(.AW(AW), .DW(DW), .TIMEOUT_CYCLES(TMO)) dut (
    .clk(clk), .rst(rst),
    .m0_cyc_i(m0_cyc_i), .m0_stb_i(m0_stb_i), .m0_we_i(m0_we_i),
    .m0_addr_i(m0_addr_i), .m0_data_i(m0_data_i), .m0_sel_i(m0_sel_i),
    .m0_data_o(m0_data_o), .m0_ack_o(m0_ack_o), .m0_err_o(m0_err_o),
    .m1_cyc_i(m1_cyc_i), .m1_stb_i(m1_stb_i), .m1_we_i(m1_we_i),
    .m1_addr_i(m1_addr_i), .m1_data_i(m1_data_i), .m1_sel_i(m1_sel_i),
    .m1_data_o(m1_data_o), .m1_ack_o(m1_ack_o), .m1_err_o(m1_err_o),
    .s_cyc_o(s_cyc_o), .s_stb_o(s_stb_o), .s_we_o(s_we_o),
    .s_addr_o(s_addr_o), .s_data_o(s_data_o), .s_sel_o(s_sel_o),
    .s_data_i(s_data_i), .s_ack_i(s_ack_i), .gnt_o(gnt_o)
  );

  // Single comparison point: count it, report a mismatch
  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h want 0x%0h", tag, obs, exp);
    end
  endtask

  // Advance one clock; inputs change and outputs are sampled 1ns after the edge
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  task automatic m0_req(input logic on, input logic we, input logic [31:0] a, input logic [31:0] d);
    m0_cyc_i = on; m0_stb_i = on; m0_we_i = we; m0_addr_i = a; m0_data_i = d; m0_sel_i = 4'hF;
  endtask

  task automatic m1_req(input logic on, input logic we, input logic [31:0] a, input logic [31:0] d);
    m1_cyc_i = on; m1_stb_i = on; m1_we_i = we; m1_addr_i = a; m1_data_i = d; m1_sel_i = 4'hF;
  endtask

  initial begin
    rst = 1'b1;
    m0_req(1'b0, 1'b0, 32'h0, 32'h0);
    m1_req(1'b0, 1'b0, 32'h0, 32'h0);
    s_data_i = 32'h0;
    s_ack_i  = 1'b0;
    step(); step();
    rst = 1'b0;
    settle();
    chk("rst_gnt", 64'(gnt_o), 64'h0);
    chk("rst_scyc", 64'(s_cyc_o), 64'h0);
    chk("rst_m0ack", 64'(m0_ack_o), 64'h0);

    // m0 read, slave acks on the second granted cycle
    m0_req(1'b1, 1'b0, 32'h0000_0100, 32'h0);
    settle();
    chk("t1_gnt_latency", 64'(gnt_o), 64'h0);
    step();
    chk("t1_gnt", 64'(gnt_o), 64'h1);
    chk("t1_scyc", 64'(s_cyc_o), 64'h1);
    chk("t1_saddr", 64'(s_addr_o), 64'h100);
    step();
    s_ack_i = 1'b1; s_data_i = 32'hDEAD_BEEF;
    settle();
    chk("t1_m0data", 64'(m0_data_o), 64'hDEAD_BEEF);
    chk("t1_m0ack", 64'(m0_ack_o), 64'h1);
    chk("t1_m1out", 64'({m1_data_o, m1_ack_o, m1_err_o}), 64'h0);
    step();
    s_ack_i = 1'b0; s_data_i = 32'h0;
    m0_req(1'b0, 1'b0, 32'h0, 32'h0);
    step();
    chk("t1_idle", 64'(gnt_o), 64'h0);

    // Simultaneous request: m1 first (both builds: last served is m0), then m0 without a bubble
    m0_req(1'b1, 1'b0, 32'h0000_0200, 32'h0);
    m1_req(1'b1, 1'b1, 32'h0000_0300, 32'h1234_5678);
    step();
    chk("t2_gnt_m1", 64'(gnt_o), 64'h2);
    chk("t2_swe", 64'(s_we_o), 64'h1);
    chk("t2_sdata", 64'(s_data_o), 64'h1234_5678);
    chk("t2_ssel", 64'(s_sel_o), 64'hF);
    chk("t2_saddr", 64'(s_addr_o), 64'h300);
    s_ack_i = 1'b1;
    settle();
    chk("t2_m1ack", 64'(m1_ack_o), 64'h1);
    chk("t2_m0ack", 64'(m0_ack_o), 64'h0);
    step();
    s_ack_i = 1'b0;
    m1_req(1'b0, 1'b0, 32'h0, 32'h0);
    settle();
    chk("t2_hold_until_edge", 64'(gnt_o), 64'h2);
    step();
    chk("t2_gnt_m0", 64'(gnt_o), 64'h1);
    chk("t2_saddr_m0", 64'(s_addr_o), 64'h200);
    s_ack_i = 1'b1;
    settle();
    chk("t2_m0ack2", 64'(m0_ack_o), 64'h1);
    step();
    s_ack_i = 1'b0;
    m0_req(1'b0, 1'b0, 32'h0, 32'h0);
    step();
    chk("t2_idle", 64'(gnt_o), 64'h0);

    // Serve m1 alone so last served = m1, then contend again
    m1_req(1'b1, 1'b0, 32'h0000_0400, 32'h0);
    step();
    s_ack_i = 1'b1;
    step();
    s_ack_i = 1'b0;
    m1_req(1'b0, 1'b0, 32'h0, 32'h0);
    step();
    chk("t3_idle", 64'(gnt_o), 64'h0);
    m0_req(1'b1, 1'b0, 32'h0000_0500, 32'h0);
    m1_req(1'b1, 1'b0, 32'h0000_0600, 32'h0);
    step();
`ifdef WB_ARB_ROUND_ROBIN_EN
    chk("t3_rr_gnt", 64'(gnt_o), 64'h1);
`else
    chk("t3_prio_gnt", 64'(gnt_o), 64'h2);
`endif
    m0_req(1'b0, 1'b0, 32'h0, 32'h0);
    m1_req(1'b0, 1'b0, 32'h0, 32'h0);
    step();
    chk("t3_idle2", 64'(gnt_o), 64'h0);

    // m1 holds cyc across three acked transfers while m0 waits (last served is not m1 in either build)
    m0_req(1'b1, 1'b0, 32'h0000_0700, 32'h0);
    m1_req(1'b1, 1'b0, 32'h0000_0800, 32'h0);
    step();
    for (int i = 0; i < 3; i++) begin
      s_ack_i = 1'b1;
      s_data_i = 32'hA000_0000 + 32'(i);
      settle();
      chk($sformatf("t4_gnt_ack%0d", i), 64'(gnt_o), 64'h2);
      chk($sformatf("t4_m1data%0d", i), 64'(m1_data_o), 64'hA000_0000 + 64'(i));
      chk($sformatf("t4_m0ack%0d", i), 64'(m0_ack_o), 64'h0);
      step();
      s_ack_i = 1'b0;
      settle();
      chk($sformatf("t4_gnt_gap%0d", i), 64'(gnt_o), 64'h2);
      step();
    end
    m1_req(1'b0, 1'b0, 32'h0, 32'h0);
    s_data_i = 32'h0;
    step();
    chk("t4_gnt_m0", 64'(gnt_o), 64'h1);
    m0_req(1'b0, 1'b0, 32'h0, 32'h0);
    step();

    // Timeout: no ack, err on the 8th granted cycle with s_cyc forced low
    m0_req(1'b1, 1'b0, 32'h0000_0900, 32'h0);
    step();
    for (int k = 1; k < int'(TMO); k++) begin
      chk($sformatf("t5_noerr%0d", k), 64'({m0_err_o, s_cyc_o}), 64'h1);
      step();
    end
    chk("t5_err", 64'(m0_err_o), 64'h1);
    chk("t5_scyc0", 64'(s_cyc_o), 64'h0);
    chk("t5_gnt_at_err", 64'(gnt_o), 64'h1);
    chk("t5_m1err", 64'(m1_err_o), 64'h0);
    step();
    chk("t5_idle", 64'(gnt_o), 64'h0);
    chk("t5_err_pulse", 64'(m0_err_o), 64'h0);
    m0_req(1'b0, 1'b0, 32'h0, 32'h0);
    step();

    // Ack on the expiry cycle wins over the timeout
    m0_req(1'b1, 1'b0, 32'h0000_0A00, 32'h0);
    step();
    for (int k = 1; k < int'(TMO); k++) step();
    s_ack_i = 1'b1;
    settle();
    chk("t5b_ackwins_err", 64'(m0_err_o), 64'h0);
    chk("t5b_ackwins_ack", 64'(m0_ack_o), 64'h1);
    chk("t5b_ackwins_scyc", 64'(s_cyc_o), 64'h1);
    step();
    s_ack_i = 1'b0;
    settle();
    chk("t5b_still_gnt", 64'(gnt_o), 64'h1);
    m0_req(1'b0, 1'b0, 32'h0, 32'h0);
    step();

    // Reset in the middle of an m1 transfer
    m1_req(1'b1, 1'b1, 32'h0000_0B00, 32'h5555_AAAA);
    step();
    s_ack_i = 1'b1;
    settle();
    chk("t6_m1ack_pre", 64'(m1_ack_o), 64'h1);
    rst = 1'b1;
    step();
    chk("t6_gnt", 64'(gnt_o), 64'h0);
    chk("t6_scyc", 64'(s_cyc_o), 64'h0);
    chk("t6_m1ack", 64'(m1_ack_o), 64'h0);
    chk("t6_sdata", 64'(s_data_o), 64'h0);
    rst = 1'b0;
    s_ack_i = 1'b0;
    m1_req(1'b0, 1'b0, 32'h0, 32'h0);
    step();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
